// File: rtl/irq_pkg.sv
// irq_pkg: shared types, constants and helpers for the interrupt sequencer
package irq_pkg;
    typedef enum logic [1:0] {IDLE, SIGNAL, SERVICE} state_t;
    localparam int CAUSE_W = 5;
    localparam logic [CAUSE_W-1:0] CAUSE_EXC = 5'd0;
    localparam int VEC_SHIFT = 3;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [CAUSE_W-1:0] c);
        return base + (32'(c) << VEC_SHIFT);
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: picks one request; round-robin from start when IRQ_PRIO_ROTATE_EN is defined,
// otherwise fixed lowest-index-wins and start is ignored.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]          req,
    input  logic [idx_w(NUM_SRC)-1:0]   start,
    output logic                        valid,
    output logic [idx_w(NUM_SRC)-1:0]   gnt
);
    localparam int IDX_W = idx_w(NUM_SRC);
`ifdef IRQ_PRIO_ROTATE_EN
    // Walk backwards so the closest index after start is the last one written.
    always_comb begin
        valid = |req;
        gnt = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (req[(int'(start) + k) % NUM_SRC]) gnt = IDX_W'((int'(start) + k) % NUM_SRC);
    end
`else
    logic unused_start;
    assign unused_start = ^start;
    always_comb begin
        valid = |req;
        gnt = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (req[k]) gnt = IDX_W'(k);
    end
`endif
endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: edge-triggered interrupt/exception sequencer with mask, EPC/cause capture and one-cycle irq pulse.
// Define IRQ_PRIO_ROTATE_EN for round-robin source selection instead of fixed priority.
module irq_ctl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC  = 4,
    parameter logic [31:0] VEC_BASE = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  src_req,
    input  logic                mask_wr,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    input  logic                exc,
    input  logic [31:0]         pc,
    input  logic                pc31,
    input  logic                eret,
    output logic                irq,
    output logic [31:0]         vector,
    output logic [31:0]         epc,
    output logic [CAUSE_W-1:0]  cause,
    output logic [NUM_SRC-1:0]  mask,
    output logic [NUM_SRC-1:0]  pending,
    output logic                dbl_fault
);
    localparam int IDX_W = idx_w(NUM_SRC);
    state_t state;
    logic [NUM_SRC-1:0] hist, edges, active, clr;
    logic [IDX_W-1:0] start, gnt;
    logic valid, take;
    logic [CAUSE_W-1:0] cause_n;
    assign edges = src_req & ~hist;
    assign active = pending & mask;
    assign take = state == IDLE && !exc && valid && !pc31;
    assign clr = take ? NUM_SRC'(1) << gnt : '0;
    assign cause_n = CAUSE_W'(gnt) + CAUSE_W'(1);
`ifdef IRQ_PRIO_ROTATE_EN
    logic [IDX_W-1:0] ptr;
    assign start = int'(ptr) == NUM_SRC - 1 ? '0 : ptr + 1'b1;
    always_ff @(posedge clk)
        if (reset) ptr <= '0;
        else if (take) ptr <= gnt;
`else
    assign start = '0;
`endif
    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
        .req   (active),
        .start (start),
        .valid (valid),
        .gnt   (gnt)
    );
    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            irq <= 1'b0;
            vector <= VEC_BASE;
            epc <= '0;
            cause <= '0;
            mask <= '0;
            pending <= '0;
            dbl_fault <= 1'b0;
            hist <= '0;
        end else begin
            hist <= src_req;
            pending <= (pending & ~clr) | edges;
            if (mask_wr) mask <= mask_wdata;
            case (state)
                IDLE: begin
                    if (exc) begin
                        epc <= pc;
                        cause <= CAUSE_EXC;
                        vector <= vec_addr(VEC_BASE, CAUSE_EXC);
                        state <= SERVICE;
                    end else if (take) begin
                        epc <= pc;
                        cause <= cause_n;
                        vector <= vec_addr(VEC_BASE, cause_n);
                        irq <= 1'b1;
                        state <= SIGNAL;
                    end
                end
                SIGNAL: begin
                    irq <= 1'b0;
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (exc) dbl_fault <= 1'b1;
                    if (eret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: scoreboard bench; expected grants are queued with the stimulus and popped on each irq pulse.
module tb_irq_ctl;
    logic clk = 0, reset = 1;
    logic [3:0] src_req = 0, mask_wdata = 0, mask, pending;
    logic mask_wr = 0, exc = 0, pc31 = 0, eret = 0, irq, dbl_fault;
    logic [31:0] pc = 0, vector, epc;
    logic [4:0] cause;
    typedef struct {logic [4:0] cause; logic [31:0] epc;} exp_t;
    exp_t sb[$];
    int n_tests = 0, n_fail = 0, irq_cnt = 0;

    irq_ctl #(.NUM_SRC(4), .VEC_BASE(32'h8000_0000)) dut (
        .clk(clk), .reset(reset), .src_req(src_req), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
        .exc(exc), .pc(pc), .pc31(pc31), .eret(eret), .irq(irq), .vector(vector), .epc(epc),
        .cause(cause), .mask(mask), .pending(pending), .dbl_fault(dbl_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] c, input logic [31:0] p);
        exp_t e;
        e.cause = c;
        e.epc = p;
        sb.push_back(e);
    endtask

    task automatic do_eret();
        eret = 1;
        tick();
        eret = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && irq) begin
            exp_t e;
            irq_cnt++;
            if (sb.size() == 0) check("irq_unexpected", 32'(irq), 32'd0);
            else begin
                e = sb.pop_front();
                check("sb_cause", 32'(cause), 32'(e.cause));
                check("sb_epc", epc, e.epc);
                check("sb_vector", vector, 32'h8000_0000 + 32'(e.cause) * 8);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int c0;
        repeat (2) tick();
        reset = 0;
        check("rst_irq", 32'(irq), 0);
        check("rst_vector", vector, 32'h8000_0000);
        check("rst_epc", epc, 0);
        check("rst_cause", 32'(cause), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_dbl", 32'(dbl_fault), 0);
        // single source, cause 3
        mask_wr = 1; mask_wdata = 4'hf; tick(); mask_wr = 0;
        check("mask_f", 32'(mask), 32'hf);
        pc = 32'h40; src_req = 4'b0100; push(3, 32'h40);
        tick();
        check("t1_pend", 32'(pending), 32'h4);
        check("t1_irq0", 32'(irq), 0);
        tick();
        check("t1_irq1", 32'(irq), 1);
        check("t1_pend_clr", 32'(pending), 0);
        tick();
        check("t1_irq_pulse", 32'(irq), 0);
        do_eret(); src_req = 0; tick();
        // two simultaneous sources
        pc = 32'h44; src_req = 4'b1010;
`ifdef IRQ_PRIO_ROTATE_EN
        push(4, 32'h44); push(2, 32'h44);
`else
        push(2, 32'h44); push(4, 32'h44);
`endif
        tick();
        check("t2_pend", 32'(pending), 32'ha);
        tick();
        check("t2_irq_a", 32'(irq), 1);
        tick();
`ifdef IRQ_PRIO_ROTATE_EN
        check("t2_pend_left", 32'(pending), 32'h2);
`else
        check("t2_pend_left", 32'(pending), 32'h8);
`endif
        do_eret();
        tick();
        check("t2_irq_b", 32'(irq), 1);
        tick(); do_eret(); src_req = 0; tick();
        // exception beats pending interrupt
        pc = 32'h100; src_req = 4'b0001; tick();
        exc = 1; tick(); exc = 0;
        check("t3_cause", 32'(cause), 0);
        check("t3_epc", epc, 32'h100);
        check("t3_irq", 32'(irq), 0);
        check("t3_pend", 32'(pending), 32'h1);
        check("t3_vector", vector, 32'h8000_0000);
        do_eret();
        pc = 32'h104; push(1, 32'h104);
        tick();
        check("t3_irq_late", 32'(irq), 1);
        check("t3_pend_clr", 32'(pending), 0);
        tick(); do_eret(); src_req = 0; tick();
        // kernel mode blocks entry
        pc31 = 1; src_req = 4'b0001; c0 = irq_cnt;
        repeat (10) tick();
        check("t4_blocked", 32'(irq_cnt - c0), 0);
        check("t4_pend", 32'(pending), 32'h1);
        pc31 = 0; pc = 32'h200; push(1, 32'h200);
        tick();
        check("t4_irq", 32'(irq), 1);
        tick();
        // double fault in SERVICE, then reset mid-service
        exc = 1; tick(); exc = 0;
        check("t5_dbl", 32'(dbl_fault), 1);
        check("t5_epc", epc, 32'h200);
        check("t5_cause", 32'(cause), 1);
        src_req = 0; reset = 1; tick(); reset = 0;
        check("t5_rst_dbl", 32'(dbl_fault), 0);
        check("t5_rst_epc", epc, 0);
        check("t5_rst_cause", 32'(cause), 0);
        check("t5_rst_mask", 32'(mask), 0);
        check("t5_rst_vec", vector, 32'h8000_0000);
        check("t5_rst_irq", 32'(irq), 0);
        // masked source, then unmask
        mask_wr = 1; mask_wdata = 0; tick(); mask_wr = 0;
        pc = 32'h300; src_req = 4'b0001; c0 = irq_cnt;
        repeat (2) tick();
        check("t6_pend", 32'(pending), 32'h1);
        check("t6_no_irq", 32'(irq_cnt - c0), 0);
        mask_wr = 1; mask_wdata = 4'b0001; push(1, 32'h300);
        tick(); mask_wr = 0;
        check("t6_irq0", 32'(irq), 0);
        tick();
        check("t6_irq1", 32'(irq), 1);
        tick();
        // eret with a new edge in the same cycle: edge pends, state returns to IDLE
        src_req = 4'b1001; eret = 1; tick(); eret = 0;
        check("t6_edge_eret", 32'(pending), 32'h8);
        // eret while idle is ignored; masked bit3 does not fire
        do_eret(); tick();
        check("t6_masked_idle", 32'(irq), 0);
        mask_wr = 1; mask_wdata = 4'hf; push(4, 32'h300); tick(); mask_wr = 0;
        tick();
        check("t6_irq_bit3", 32'(irq), 1);
        tick(); tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
